sprite_line_scan: RTL and testbench

Per-scanline sprite evaluator on the read side of the sprite attribute RAM. At the start of each line it walks all 64 entries through `spr_sel` and tests each sprite's Y against the requested line. Each visible sprite is emitted, in ascending index order, as a ready/valid record to the line renderer, with tile index and row already resolved for height and vertical flip. Emission is capped at `MAX_PER_LINE` sprites, and an overflow flag is raised when a further sprite is found.

---
 rtl/sprite_line_scan.sv | 180 ++++++++++++++++++
 tb/tb_sprite_line_scan.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_scan.sv
// sprite_line_scan
//   Per-scanline sprite evaluator on the read side of the sprite attribute RAM.
//   On line_start it walks all 64 attribute entries through spr_sel and tests
//   each sprite's Y against the latched line. Each visible sprite is emitted in
//   ascending index order as a ready/valid record. The tile index and row are
//   already resolved for height and vertical flip. At most MAX_PER_LINE records
//   are emitted per line. A further hit raises a sticky overflow flag and ends
//   the scan early.
//
// Ports
//   clk, reset              clock, asynchronous active-low reset
//   line_start, line_y      start pulse and line to evaluate (sampled on start)
//   spr_sel                 attribute RAM read address
//   spr_*                   attributes of entry spr_sel (combinational read)
//   out_valid, out_ready    record handshake
//   out_x .. out_hflip      emitted record fields
//   busy                    high whenever not idle
//   done                    one-cycle pulse: scan complete, last record taken
//   overflow                more than MAX_PER_LINE hits on this line (sticky)
module sprite_line_scan #(
    parameter int MAX_PER_LINE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       line_start,
    input  logic [7:0] line_y,
    output logic [5:0] spr_sel,
    input  logic [8:0] spr_x,
    input  logic [7:0] spr_y,
    input  logic [9:0] spr_idx,
    input  logic       spr_priority,
    input  logic [1:0] spr_palette,
    input  logic       spr_h16,
    input  logic       spr_vflip,
    input  logic       spr_hflip,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] out_x,
    output logic [9:0] out_idx,
    output logic [2:0] out_row,
    output logic [1:0] out_palette,
    output logic       out_priority,
    output logic       out_hflip,
    output logic       busy,
    output logic       done,
    output logic       overflow
);

    localparam logic [6:0] MAX_CNT = 7'(MAX_PER_LINE);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

    // delta is line - Y modulo 256, so sprites near the bottom wrap to the top.
    function automatic logic sprite_hit(input logic [7:0] delta, input logic h16);
        return h16 ? (delta < 8'd16) : (delta < 8'd8);
    endfunction

    function automatic logic [3:0] resolve_row(input logic [3:0] delta,
                                               input logic h16,
                                               input logic vflip);
        logic [3:0] last_row;
        last_row = h16 ? 4'd15 : 4'd7;
        return vflip ? (last_row - delta) : delta;
    endfunction

    state_t     state;
    logic [7:0] line_y_r;
    logic [6:0] count;
    logic       done_r;
    logic       ovf_r;

    logic       vld_p1;
    logic [8:0] x_p1;
    logic [9:0] idx_p1;
    logic [2:0] row_p1;
    logic [1:0] pal_p1;
    logic       pri_p1;
    logic       hflip_p1;

    logic [7:0] delta_p0;
    logic       hit_p0;
    logic [3:0] row_p0;
    logic [9:0] idx_p0;
    logic       cap_p0;
    logic       accept_p0;
    logic       load_p0;
    logic       vld_nxt;

    // Stage p0: hit test and row resolve on the entry currently addressed
    always_comb begin
        delta_p0  = line_y_r - spr_y;
        hit_p0    = sprite_hit(delta_p0, spr_h16);
        row_p0    = resolve_row(delta_p0[3:0], spr_h16, spr_vflip);
        // Bottom half of a 16-line sprite lives in the next tile.
        idx_p0    = spr_idx + {9'd0, row_p0[3]};
        cap_p0    = (count >= MAX_CNT);
        accept_p0 = !vld_p1 || out_ready;
        load_p0   = (state == S_SCAN) && hit_p0 && !cap_p0 && accept_p0;
        vld_nxt   = load_p0 || (vld_p1 && !out_ready);
    end

    // Stage p1: one-entry output record register and scan control
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            spr_sel  <= 6'd0;
            line_y_r <= 8'd0;
            count    <= 7'd0;
            done_r   <= 1'b0;
            ovf_r    <= 1'b0;
            vld_p1   <= 1'b0;
            x_p1     <= 9'd0;
            idx_p1   <= 10'd0;
            row_p1   <= 3'd0;
            pal_p1   <= 2'd0;
            pri_p1   <= 1'b0;
            hflip_p1 <= 1'b0;
        end else if (line_start) begin
            // Start, or abort-and-restart from any state; a pending record is dropped.
            state    <= S_SCAN;
            line_y_r <= line_y;
            spr_sel  <= 6'd0;
            count    <= 7'd0;
            ovf_r    <= 1'b0;
            vld_p1   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            vld_p1 <= vld_nxt;
            if (load_p0) begin
                x_p1     <= spr_x;
                idx_p1   <= idx_p0;
                row_p1   <= row_p0[2:0];
                pal_p1   <= spr_palette;
                pri_p1   <= spr_priority;
                hflip_p1 <= spr_hflip;
                count    <= count + 7'd1;
            end
            case (state)
                S_IDLE: ;
                S_SCAN: begin
                    if (hit_p0 && cap_p0) begin
                        ovf_r  <= 1'b1;
                        state  <= S_DRAIN;
                        done_r <= !vld_nxt;
                    end else if (!hit_p0 || load_p0) begin
                        if (spr_sel == 6'd63) begin
                            spr_sel <= 6'd0;
                            state   <= S_DRAIN;
                            done_r  <= !vld_nxt;
                        end else begin
                            spr_sel <= spr_sel + 6'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    // done is high for the final DRAIN cycle, once the register is empty.
                    if (done_r) begin
                        done_r <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        done_r <= !vld_nxt;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign out_valid    = vld_p1;
    assign out_x        = x_p1;
    assign out_idx      = idx_p1;
    assign out_row      = row_p1;
    assign out_palette  = pal_p1;
    assign out_priority = pri_p1;
    assign out_hflip    = hflip_p1;
    assign busy         = (state != S_IDLE);
    assign done         = done_r;
    assign overflow     = ovf_r;

endmodule

// File: tb/tb_sprite_line_scan.sv
module tb_sprite_line_scan;

    localparam int MAXP = 16;

    typedef struct packed {
        logic [8:0] x;
        logic [9:0] idx;
        logic [2:0] row;
        logic [1:0] pal;
        logic       pri;
        logic       hflip;
    } rec_t;

    typedef struct {
        int         s;
        logic [8:0] x;
        logic [7:0] y;
        logic [9:0] idx;
        logic       h16;
        logic       vflip;
        logic       hflip;
        logic [1:0] pal;
        logic       pri;
        logic [7:0] line;
        int         exp_hit;
        logic [8:0] ex;
        logic [9:0] eidx;
        logic [2:0] erow;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       line_start;
    logic [7:0] line_y;
    logic [5:0] spr_sel;
    logic [8:0] spr_x;
    logic [7:0] spr_y;
    logic [9:0] spr_idx;
    logic       spr_priority;
    logic [1:0] spr_palette;
    logic       spr_h16, spr_vflip, spr_hflip;
    logic       out_valid, out_ready;
    logic [8:0] out_x;
    logic [9:0] out_idx;
    logic [2:0] out_row;
    logic [1:0] out_palette;
    logic       out_priority, out_hflip;
    logic       busy, done, overflow;

    logic [8:0] ram_x     [64];
    logic [7:0] ram_y     [64];
    logic [9:0] ram_idx   [64];
    logic       ram_pri   [64];
    logic [1:0] ram_pal   [64];
    logic       ram_h16   [64];
    logic       ram_vflip [64];
    logic       ram_hflip [64];

    logic       bp_mode, ready_fix, rnd_ready;
    logic [7:0] cur_line;
    rec_t       sb_q[$];
    int         n_vec = 0;
    int         n_miss = 0;
    int         n_rx = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rnd_ready <= 1'($urandom_range(0, 1));
    assign out_ready = bp_mode ? rnd_ready : ready_fix;

    assign spr_x        = ram_x[spr_sel];
    assign spr_y        = ram_y[spr_sel];
    assign spr_idx      = ram_idx[spr_sel];
    assign spr_priority = ram_pri[spr_sel];
    assign spr_palette  = ram_pal[spr_sel];
    assign spr_h16      = ram_h16[spr_sel];
    assign spr_vflip    = ram_vflip[spr_sel];
    assign spr_hflip    = ram_hflip[spr_sel];

    sprite_line_scan #(.MAX_PER_LINE(MAXP)) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .line_y(line_y),
        .spr_sel(spr_sel), .spr_x(spr_x), .spr_y(spr_y), .spr_idx(spr_idx),
        .spr_priority(spr_priority), .spr_palette(spr_palette), .spr_h16(spr_h16),
        .spr_vflip(spr_vflip), .spr_hflip(spr_hflip),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_idx(out_idx),
        .out_row(out_row), .out_palette(out_palette), .out_priority(out_priority),
        .out_hflip(out_hflip), .busy(busy), .done(done), .overflow(overflow)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: actual %0h, required %0h", nm, act, req);
        end
    endtask

    // Negedge sample point; every accepted record is checked against the scoreboard.
    task automatic neg();
        rec_t got, expr;
        @(negedge clk);
        if (out_valid && out_ready) begin
            got = {out_x, out_idx, out_row, out_palette, out_priority, out_hflip};
            n_rx++;
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL rec_extra: actual record %h, required none", got);
            end else begin
                expr = sb_q.pop_front();
                chk("record", {6'd0, got}, {6'd0, expr});
            end
        end
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        neg();
        pos();
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 64; i++) begin
            ram_x[i]     = 9'(i * 3 + 1);
            ram_y[i]     = 8'd100;
            ram_idx[i]   = 10'(i + 5);
            ram_pri[i]   = 1'(i);
            ram_pal[i]   = 2'(i);
            ram_h16[i]   = 1'b0;
            ram_vflip[i] = 1'b0;
            ram_hflip[i] = 1'(i >> 1);
        end
    endtask

    function automatic bit tb_hit(input int i, input logic [7:0] line);
        int d;
        d = (int'(line) - int'(ram_y[i]) + 256) % 256;
        return d < (ram_h16[i] ? 16 : 8);
    endfunction

    // Reference model: pushes the records expected for this line in sprite order.
    task automatic load_model(input logic [7:0] line, output int nexp, output bit eovf);
        nexp = 0;
        eovf = 0;
        for (int i = 0; i < 64; i++) begin
            int d, h, r;
            rec_t rc;
            d = (int'(line) - int'(ram_y[i]) + 256) % 256;
            h = ram_h16[i] ? 16 : 8;
            if (d < h) begin
                if (nexp == MAXP) begin
                    eovf = 1;
                    break;
                end
                r = ram_vflip[i] ? (h - 1 - d) : d;
                rc.x     = ram_x[i];
                rc.idx   = 10'((int'(ram_idx[i]) + r / 8) % 1024);
                rc.row   = 3'(r % 8);
                rc.pal   = ram_pal[i];
                rc.pri   = ram_pri[i];
                rc.hflip = ram_hflip[i];
                sb_q.push_back(rc);
                nexp++;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the sampling edge E0.
    task automatic start(input logic [7:0] l);
        cur_line   = l;
        line_y     = l;
        line_start = 1'b1;
        neg();
        pos();
        line_start = 1'b0;
        line_y     = 8'($urandom);
    endtask

    // Cycle c is the one following edge E(c-1); returns at the negedge of the done cycle.
    task automatic wait_done(input int c0, input int budget, input bit stall_chk, output int dc);
        bit         pst;
        logic [5:0] psel;
        pst = 0;
        psel = 6'd0;
        dc = -1;
        for (int c = c0; c <= budget; c++) begin
            neg();
            if (stall_chk && pst) chk("stall_hold_sel", 32'(spr_sel), 32'(psel));
            pst  = busy && out_valid && !out_ready && (spr_sel != 6'd0) &&
                   tb_hit(int'(spr_sel), cur_line);
            psel = spr_sel;
            if (done) begin
                dc = c;
                break;
            end
            pos();
        end
        if (dc < 0) chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic setup_bp();
        clear_ram();
        ram_y[10]     = 8'd70;
        ram_y[11]     = 8'd70;
        ram_vflip[11] = 1'b1;
        ram_y[40]     = 8'd70;
        ram_h16[40]   = 1'b1;
        ram_vflip[40] = 1'b1;
    endtask

    vec_t vt[9];

    initial begin
        int   dc, nexp, rx0;
        bit   eovf;
        rec_t er;

        vt[0] = '{5,  9'd300, 8'd40,  10'h120, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 8'd43,  1, 9'd300, 10'h121, 3'd4};
        vt[1] = '{0,  9'd17,  8'd250, 10'h3FF, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 8'd3,   1, 9'd17,  10'h000, 3'd1};
        vt[2] = '{0,  9'd17,  8'd250, 10'h3FF, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 8'd10,  0, 9'd0,   10'h000, 3'd0};
        vt[3] = '{63, 9'd511, 8'd7,   10'h050, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 8'd14,  1, 9'd511, 10'h050, 3'd7};
        vt[4] = '{20, 9'd0,   8'd200, 10'h200, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'd200, 1, 9'd0,   10'h200, 3'd7};
        vt[5] = '{20, 9'd0,   8'd200, 10'h200, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'd208, 0, 9'd0,   10'h000, 3'd0};
        vt[6] = '{33, 9'd100, 8'd60,  10'h010, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 8'd75,  1, 9'd100, 10'h010, 3'd0};
        vt[7] = '{33, 9'd100, 8'd60,  10'h010, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 8'd75,  1, 9'd100, 10'h011, 3'd7};
        vt[8] = '{40, 9'd256, 8'd255, 10'h0FF, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 8'd2,   1, 9'd256, 10'h0FF, 3'd3};

        reset = 1'b0;
        line_start = 1'b0;
        line_y = 8'd0;
        cur_line = 8'd0;
        ready_fix = 1'b1;
        bp_mode = 1'b0;
        clear_ram();

        // Reset state
        pos();
        pos();
        neg();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sel", 32'(spr_sel), 0);
        chk("rst_fields", 32'({out_x, out_idx, out_row, out_palette, out_priority, out_hflip}), 0);
        chk("rst_done_ovf", 32'({done, overflow}), 0);
        #2 reset = 1'b1;
        pos();

        // No hits: done in cycle 65, busy low from cycle 66
        clear_ram();
        sb_q.delete();
        load_model(8'd20, nexp, eovf);
        rx0 = n_rx;
        start(8'd20);
        neg();
        chk("start_busy", 32'(busy), 1);
        chk("start_sel", 32'(spr_sel), 0);
        pos();
        wait_done(2, 400, 1'b0, dc);
        chk("nohit_done_cycle", 32'(dc), 65);
        chk("nohit_ovf", 32'(overflow), 0);
        pos();
        neg();
        chk("nohit_busy_after", 32'(busy), 0);
        chk("nohit_done_pulse", 32'(done), 0);
        pos();
        chk("nohit_records", 32'(n_rx - rx0), 0);

        // Single-sprite table: height, flip, wrap, index carry
        for (int v = 0; v < 9; v++) begin
            clear_ram();
            ram_x[vt[v].s]     = vt[v].x;
            ram_y[vt[v].s]     = vt[v].y;
            ram_idx[vt[v].s]   = vt[v].idx;
            ram_h16[vt[v].s]   = vt[v].h16;
            ram_vflip[vt[v].s] = vt[v].vflip;
            ram_hflip[vt[v].s] = vt[v].hflip;
            ram_pal[vt[v].s]   = vt[v].pal;
            ram_pri[vt[v].s]   = vt[v].pri;
            sb_q.delete();
            if (vt[v].exp_hit != 0) begin
                er = '{vt[v].ex, vt[v].eidx, vt[v].erow, vt[v].pal, vt[v].pri, vt[v].hflip};
                sb_q.push_back(er);
            end
            rx0 = n_rx;
            start(vt[v].line);
            wait_done(1, 400, 1'b0, dc);
            chk("vec_ovf", 32'(overflow), 0);
            pos();
            chk("vec_records", 32'(n_rx - rx0), 32'(vt[v].exp_hit));
            chk("vec_sb_empty", 32'(sb_q.size()), 0);
        end

        // Overflow: every sprite hits, only the first MAXP are emitted
        clear_ram();
        for (int i = 0; i < 64; i++) ram_y[i] = 8'd50;
        sb_q.delete();
        load_model(8'd50, nexp, eovf);
        rx0 = n_rx;
        start(8'd50);
        wait_done(1, 400, 1'b0, dc);
        chk("ovf_done_cycle", 32'(dc), 18);
        chk("ovf_flag", 32'(overflow), 32'(eovf));
        pos();
        chk("ovf_records", 32'(n_rx - rx0), 32'(MAXP));
        chk("ovf_sb_empty", 32'(sb_q.size()), 0);
        repeat (3) cyc();
        neg();
        chk("ovf_sticky", 32'(overflow), 1);
        pos();

        // Backpressure with random out_ready
        setup_bp();
        sb_q.delete();
        load_model(8'd70, nexp, eovf);
        bp_mode = 1'b1;
        rx0 = n_rx;
        start(8'd70);
        wait_done(1, 3000, 1'b1, dc);
        chk("bp_sb_empty_at_done", 32'(sb_q.size()), 0);
        chk("bp_valid_at_done", 32'(out_valid), 0);
        pos();
        bp_mode = 1'b0;
        chk("bp_records", 32'(n_rx - rx0), 3);

        // Restart mid-scan while a record is held
        setup_bp();
        ready_fix = 1'b0;
        sb_q.delete();
        load_model(8'd70, nexp, eovf);
        start(8'd70);
        repeat (20) cyc();
        neg();
        chk("rs_pre_valid", 32'(out_valid), 1);
        chk("rs_pre_sel", 32'(spr_sel), 11);
        pos();
        sb_q.delete();
        load_model(8'd70, nexp, eovf);
        rx0 = n_rx;
        start(8'd70);
        neg();
        chk("rs_valid", 32'(out_valid), 0);
        chk("rs_sel", 32'(spr_sel), 0);
        chk("rs_busy", 32'(busy), 1);
        pos();
        ready_fix = 1'b1;
        wait_done(2, 400, 1'b0, dc);
        pos();
        chk("rs_records", 32'(n_rx - rx0), 3);
        chk("rs_sb_empty", 32'(sb_q.size()), 0);

        // Asynchronous reset mid-scan
        setup_bp();
        ready_fix = 1'b0;
        sb_q.delete();
        start(8'd70);
        repeat (20) cyc();
        neg();
        chk("ar_pre_valid", 32'(out_valid), 1);
        pos();
        reset = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_sel", 32'(spr_sel), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_fields", 32'({out_x, out_idx, out_row, out_palette, out_priority, out_hflip}), 0);
        chk("ar_done_ovf", 32'({done, overflow}), 0);
        #2 reset = 1'b1;
        ready_fix = 1'b1;
        sb_q.delete();
        pos();
        neg();
        chk("ar_idle_after", 32'(busy), 0);
        pos();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
